// File: rtl/rv32i_ram_loader_if.sv
// Byte-stream handshake between the host bridge (master) and the RAM image loader (slave).
interface rv32i_ram_loader_if;
  logic       in_valid;
  logic [7:0] in_data;
  logic       in_ready;

  modport master (output in_valid, output in_data, input in_ready);
  modport slave  (input in_valid, input in_data, output in_ready);
endinterface

// File: rtl/rv32i_ram_loader.sv
// Boot-time image loader: packs a byte stream little-endian into words and stores them to RAM,
// owning the RAM port while loading and passing CPU requests through otherwise.
package rv32i_pkg;
  typedef enum logic [1:0] {MEM_NOP = 2'd0, MEM_LOAD = 2'd1, MEM_STORE = 2'd2} mem_op_e;
  typedef enum logic [1:0] {RAM_MASK_B = 2'd0, RAM_MASK_H = 2'd1, RAM_MASK_W = 2'd2} ram_mask_e;
endpackage

module rv32i_ram_loader
  import rv32i_pkg::*;
#(
  parameter int unsigned LEN_WIDTH = 21
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     start,
  input  logic [31:0]              base_addr,
  input  logic [LEN_WIDTH-1:0]     byte_count,
  rv32i_ram_loader_if.slave        stream,
  output logic                     busy,
  output logic                     done,
  input  logic [31:0]              cpu_addr,
  input  logic [31:0]              cpu_wdata,
  input  mem_op_e                  cpu_mem_op,
  input  ram_mask_e                cpu_ram_mask,
  output logic [31:0]              cpu_rdata,
  output logic [31:0]              ram_addr,
  output logic [31:0]              ram_wdata,
  output mem_op_e                  ram_mem_op,
  output ram_mask_e                ram_mask,
  input  logic [31:0]              ram_rdata
);

  typedef enum logic [2:0] {StIdle, StCollect, StWrite, StTail, StDone} state_e;

  state_e               state_q, state_d;
  logic [31:0]          waddr_q, waddr_d;
  logic [31:0]          word_q, word_d;
  logic [LEN_WIDTH-1:0] len_q, len_d;
  logic [LEN_WIDTH-1:0] cnt_q, cnt_d;
  logic [2:0]           lane_q, lane_d;
  logic [1:0]           tail_q, tail_d;

  always_comb begin
    state_d = state_q;
    waddr_d = waddr_q;
    word_d  = word_q;
    len_d   = len_q;
    cnt_d   = cnt_q;
    lane_d  = lane_q;
    tail_d  = tail_q;
    unique case (state_q)
      StIdle, StDone: begin
        if (start) begin
          waddr_d = {base_addr[31:2], 2'b00};
          len_d   = byte_count;
          cnt_d   = '0;
          lane_d  = '0;
          word_d  = '0;
          tail_d  = '0;
          state_d = (byte_count == '0) ? StDone : StCollect;
        end
      end
      StCollect: begin
        if (stream.in_valid) begin
          word_d[{lane_q[1:0], 3'b000} +: 8] = stream.in_data;
          lane_d = lane_q + 3'd1;
          cnt_d  = cnt_q + 1'b1;
          if (lane_q == 3'd3) begin
            state_d = StWrite;
          end else if (cnt_d == len_q) begin
            state_d = StTail;
          end
        end
      end
      StWrite: begin
        waddr_d = waddr_q + 32'd4;
        lane_d  = '0;
        word_d  = '0;
        state_d = (cnt_q == len_q) ? StDone : StCollect;
      end
      StTail: begin
        // One byte store per cycle until every collected lane has been flushed.
        tail_d = tail_q + 2'd1;
        if ({1'b0, tail_q} + 3'd1 == lane_q) begin
          state_d = StDone;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= StIdle;
      waddr_q <= '0;
      word_q  <= '0;
      len_q   <= '0;
      cnt_q   <= '0;
      lane_q  <= '0;
      tail_q  <= '0;
    end else begin
      state_q <= state_d;
      waddr_q <= waddr_d;
      word_q  <= word_d;
      len_q   <= len_d;
      cnt_q   <= cnt_d;
      lane_q  <= lane_d;
      tail_q  <= tail_d;
    end
  end

  assign busy            = (state_q == StCollect) || (state_q == StWrite) || (state_q == StTail);
  assign done            = (state_q == StDone);
  assign stream.in_ready = (state_q == StCollect);
  assign cpu_rdata       = ram_rdata;

  // Store gating depends only on state, so an asserted reset can never issue a loader store.
  always_comb begin
    ram_addr   = cpu_addr;
    ram_wdata  = cpu_wdata;
    ram_mem_op = cpu_mem_op;
    ram_mask   = cpu_ram_mask;
    case (state_q)
      StCollect: begin
        ram_addr   = waddr_q;
        ram_wdata  = '0;
        ram_mem_op = mem_op_e'(2'd0);
        ram_mask   = RAM_MASK_W;
      end
      StWrite: begin
        ram_addr   = waddr_q;
        ram_wdata  = word_q;
        ram_mem_op = MEM_STORE;
        ram_mask   = RAM_MASK_W;
      end
      StTail: begin
        ram_addr   = waddr_q + {30'b0, tail_q};
        ram_wdata  = {24'b0, word_q[{tail_q, 3'b000} +: 8]};
        ram_mem_op = MEM_STORE;
        ram_mask   = RAM_MASK_B;
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_rv32i_ram_loader.sv
// Scoreboard bench for rv32i_ram_loader: loads push expected stores, a monitor pops and compares.
module tb_rv32i_ram_loader;
  import rv32i_pkg::*;

  localparam int LW = 21;

  typedef struct packed {
    logic [31:0] addr;
    logic [31:0] data;
    ram_mask_e   mask;
  } store_t;

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic          start = 1'b0;
  logic [31:0]   base_addr = '0;
  logic [LW-1:0] byte_count = '0;
  logic          busy, done;
  logic [31:0]   cpu_addr = '0, cpu_wdata = '0, ram_rdata = '0;
  logic [31:0]   cpu_rdata, ram_addr, ram_wdata;
  mem_op_e       cpu_mem_op = MEM_NOP, ram_mem_op;
  ram_mask_e     cpu_ram_mask = RAM_MASK_W, ram_mask;

  rv32i_ram_loader_if stream_if ();

  int     total = 0;
  int     bad = 0;
  bit     pt_hold = 1'b0;
  bit     aborted = 1'b0;
  bit     saw_ready = 1'b0;
  store_t exp_q[$];

  rv32i_ram_loader #(.LEN_WIDTH(LW)) dut (
    .clk          (clk),
    .rst          (rst),
    .start        (start),
    .base_addr    (base_addr),
    .byte_count   (byte_count),
    .stream       (stream_if.slave),
    .busy         (busy),
    .done         (done),
    .cpu_addr     (cpu_addr),
    .cpu_wdata    (cpu_wdata),
    .cpu_mem_op   (cpu_mem_op),
    .cpu_ram_mask (cpu_ram_mask),
    .cpu_rdata    (cpu_rdata),
    .ram_addr     (ram_addr),
    .ram_wdata    (ram_wdata),
    .ram_mem_op   (ram_mem_op),
    .ram_mask     (ram_mask),
    .ram_rdata    (ram_rdata)
  );

  always #5 clk = ~clk;

  function automatic void check(input string name, input logic [31:0] act,
                                input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endfunction

  // Reference model: whole words first, then the leftover bytes as single-byte stores.
  function automatic void push_expected(input logic [31:0] base, input logic [7:0] b[$]);
    logic [31:0] a;
    int          nw;
    a  = {base[31:2], 2'b00};
    nw = b.size() / 4;
    for (int w = 0; w < nw; w++) begin
      exp_q.push_back('{addr: a + 32'(4 * w),
                        data: {b[4*w+3], b[4*w+2], b[4*w+1], b[4*w]},
                        mask: RAM_MASK_W});
    end
    for (int i = 0; i < b.size() % 4; i++) begin
      exp_q.push_back('{addr: a + 32'(4 * nw + i), data: {24'b0, b[4*nw+i]},
                        mask: RAM_MASK_B});
    end
  endfunction

  function automatic int exp_cycles(input int n);
    if (n == 0) return 1;
    return 1 + 5 * (n / 4) + 2 * (n % 4);
  endfunction

  // Random CPU traffic; during busy any CPU store that leaks shows up as a scoreboard error.
  initial begin
    forever begin
      @(negedge clk);
      if (!pt_hold) begin
        cpu_addr     = $urandom;
        cpu_wdata    = $urandom;
        cpu_mem_op   = mem_op_e'(2'($urandom_range(2)));
        cpu_ram_mask = ram_mask_e'(2'($urandom_range(2)));
        ram_rdata    = $urandom;
      end
    end
  end

  initial begin : monitor
    store_t e;
    forever begin
      @(negedge clk);
      #2;
      if (stream_if.in_ready) saw_ready = 1'b1;
      check("rdata_pass", cpu_rdata, ram_rdata);
      if (!busy) begin
        check("pt_addr", ram_addr, cpu_addr);
        check("pt_wdata", ram_wdata, cpu_wdata);
        check("pt_op", 32'(ram_mem_op), 32'(cpu_mem_op));
        check("pt_mask", 32'(ram_mask), 32'(cpu_ram_mask));
      end else if (ram_mem_op == MEM_STORE) begin
        if (exp_q.size() == 0) begin
          total++;
          bad++;
          $display("FAIL unexpected_store: got store addr %h data %h, expected none",
                   ram_addr, ram_wdata);
        end else begin
          e = exp_q.pop_front();
          check("st_addr", ram_addr, e.addr);
          check("st_data", ram_wdata, e.data);
          check("st_mask", 32'(ram_mask), 32'(e.mask));
        end
      end
    end
  end

  task automatic stream_bytes(input logic [7:0] b[$], input int gap, input int abort_after);
    int i = 0;
    int guard = 0;
    bit acc;
    while (i < b.size() && guard < 5000) begin
      if (abort_after >= 0 && i == abort_after) begin
        @(negedge clk);
        stream_if.in_valid = 1'b0;
        rst = 1'b1;
        aborted = 1'b1;
        #1;
        check("abort_busy", 32'(busy), 32'd0);
        check("abort_done", 32'(done), 32'd0);
        check("abort_ready", 32'(stream_if.in_ready), 32'd0);
        @(negedge clk);
        rst = 1'b0;
        return;
      end
      @(negedge clk);
      stream_if.in_valid = ($urandom_range(99) >= gap);
      stream_if.in_data  = b[i];
      acc = stream_if.in_valid && stream_if.in_ready;
      @(posedge clk);
      if (acc) i++;
      guard++;
    end
    @(negedge clk);
    stream_if.in_valid = 1'b0;
    if (guard >= 5000) begin
      total++;
      bad++;
      $display("FAIL stream_timeout: got %0d bytes accepted, expected %0d", i, b.size());
    end
  endtask

  task automatic do_load(input logic [31:0] base, input logic [7:0] b[$], input int gap,
                         input int abort_after, input int pulse_at, output int cyc);
    int c = 0;
    aborted = 1'b0;
    if (abort_after < 0) push_expected(base, b);
    @(negedge clk);
    start      = 1'b1;
    base_addr  = base;
    byte_count = LW'(b.size());
    @(posedge clk);
    #1 start = 1'b0;
    fork
      stream_bytes(b, gap, abort_after);
      begin
        do begin
          @(negedge clk);
          c++;
        end while (!done && !aborted && c < 2000);
      end
      if (pulse_at > 0) begin
        repeat (pulse_at) @(negedge clk);
        start      = 1'b1;
        base_addr  = 32'h0000_1000;
        byte_count = LW'(3);
        @(negedge clk);
        start = 1'b0;
      end
    join
    cyc = c;
  endtask

  initial begin : stim
    logic [7:0] b[$];
    int         cyc;
    int         n;
    int         gap;

    stream_if.in_valid = 1'b0;
    stream_if.in_data  = '0;
    #1 rst = 1'b1;
    repeat (3) @(negedge clk);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_done", 32'(done), 32'd0);
    check("rst_ready", 32'(stream_if.in_ready), 32'd0);
    rst = 1'b0;
    repeat (2) @(negedge clk);

    // Two full words, back-to-back stream.
    b = '{8'h11, 8'h22, 8'h33, 8'h44, 8'h55, 8'h66, 8'h77, 8'h88};
    do_load(32'h0000_0100, b, 0, -1, 0, cyc);
    check("t1_cycles", cyc, 32'd11);
    check("t1_done", 32'(done), 32'd1);

    // Misaligned base and a two-byte tail.
    b = '{8'hA0, 8'hA1, 8'hA2, 8'hA3, 8'hA4, 8'hA5};
    do_load(32'h0000_0203, b, 0, -1, 0, cyc);
    check("t2_cycles", cyc, 32'd10);
    check("t2_done", 32'(done), 32'd1);

    // Idle pass-through, then hold a CPU store across a load that gets aborted.
    pt_hold = 1'b1;
    @(negedge clk);
    cpu_mem_op   = MEM_STORE;
    cpu_addr     = 32'h0000_0040;
    cpu_ram_mask = RAM_MASK_H;
    cpu_wdata    = 32'hCAFE_F00D;
    #1;
    check("t5_op", 32'(ram_mem_op), 32'(MEM_STORE));
    check("t5_addr", ram_addr, 32'h0000_0040);
    check("t5_mask", 32'(ram_mask), 32'(RAM_MASK_H));
    check("t5_wdata", ram_wdata, 32'hCAFE_F00D);

    b.delete();
    for (int k = 0; k < 16; k++) b.push_back(8'($urandom));
    do_load(32'h0000_0800, b, 40, 3, 0, cyc);
    check("t4_aborted", 32'(aborted), 32'd1);
    check("t4_idle_busy", 32'(busy), 32'd0);
    check("t4_idle_done", 32'(done), 32'd0);
    pt_hold = 1'b0;

    b.delete();
    for (int k = 0; k < 7; k++) b.push_back(8'($urandom));
    do_load(32'h0000_0300, b, 0, -1, 0, cyc);
    check("t4_reload_cycles", cyc, 32'(exp_cycles(7)));
    check("t4_reload_done", 32'(done), 32'd1);

    // Zero-length image from a clean idle state.
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    saw_ready = 1'b0;
    b.delete();
    do_load(32'h0000_0500, b, 0, -1, 0, cyc);
    check("t3_cycles", cyc, 32'd1);
    check("t3_done", 32'(done), 32'd1);
    repeat (2) @(negedge clk);
    check("t3_never_ready", 32'(saw_ready), 32'd0);

    // Address wrap, with a stray start pulse mid-load.
    b = '{8'h01, 8'h02, 8'h03, 8'h04, 8'h05, 8'h06, 8'h07, 8'h08};
    do_load(32'hFFFF_FFFC, b, 0, -1, 3, cyc);
    check("t6_cycles", cyc, 32'd11);
    check("t6_done", 32'(done), 32'd1);

    for (int t = 0; t < 8; t++) begin
      b.delete();
      n = $urandom_range(23, 1);
      for (int k = 0; k < n; k++) b.push_back(8'($urandom));
      gap = (t % 2 == 1) ? 30 : 0;
      do_load($urandom, b, gap, -1, 0, cyc);
      if (gap == 0) check("rand_cycles", cyc, 32'(exp_cycles(n)));
      check("rand_done", 32'(done), 32'd1);
    end

    repeat (3) @(negedge clk);
    check("queue_empty", 32'(exp_q.size()), 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
